// File: rtl/database_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : database_scheduler
//  Description : Round-robin arbiter for the shared Haar classifier database.
//                Grants one scale engine at a time, restarts the database
//                indices, enables the sweep until every stage reports end,
//                and pulses a per-requester done. Aborts cleanly when the
//                owner withdraws its request.
//  Revision    : 1.0 - initial release
// ============================================================================
module database_scheduler #(
    parameter int NUM_REQ    = 5,
    parameter int NUM_STAGES = 25,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    database_request,
    input  logic [NUM_STAGES-1:0] end_database,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic [2:0]            o_grant_index,
    output logic                  o_database_reset,
    output logic                  o_database_enable,
    output logic [NUM_REQ-1:0]    o_sweep_done,
    output logic                  o_busy
);

    // Gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int                c_CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(GAP_CYCLES - 1);
    // Pointer starts at the last requester so the first search begins at 0.
    localparam logic [2:0]        c_PTR_INIT = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESTART = 2'd1,
        S_SWEEP   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [2:0]           idx_q, idx_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic                 w_found;
    logic [2:0]           w_sel_idx;
    int                   w_cand;
    logic                 w_owner_req;
    logic                 w_all_end;

    // Owner's request is isolated through the one-hot grant, so non-owner
    // requests cannot influence an active sweep.
    assign w_owner_req = |(grant_q & database_request);
    assign w_all_end   = &end_database;

    // Round-robin search: first set request strictly after ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!w_found && |(database_request & (NUM_REQ'(1) << w_cand))) begin
                w_found   = 1'b1;
                w_sel_idx = 3'(w_cand);
            end
        end
    end

    // Next-state logic; outputs are all decoded from registers below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d = NUM_REQ'(1) << w_sel_idx;
                    idx_d   = w_sel_idx;
                    ptr_d   = w_sel_idx;
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                if (!w_owner_req) begin
                    grant_d = '0;
                    cnt_d   = c_GAP_LOAD;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                // Completion takes priority over a same-cycle withdrawal.
                if (w_all_end) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    cnt_d   = c_GAP_LOAD;
                    state_d = S_RELEASE;
                end else if (!w_owner_req) begin
                    grant_d = '0;
                    cnt_d   = c_GAP_LOAD;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and grant registers; asynchronous reset drops everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= c_PTR_INIT;
            idx_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign o_grant           = grant_q;
    assign o_grant_index     = idx_q;
    assign o_database_reset  = (state_q == S_RESTART);
    assign o_database_enable = (state_q == S_SWEEP);
    assign o_sweep_done      = done_q;
    assign o_busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_database_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_database_scheduler
//  Description : Directed and random checks of the round-robin database
//                scheduler with an expected-grant/done scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_database_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic [24:0] endb;
    logic [4:0]  o_grant;
    logic [2:0]  o_grant_index;
    logic        o_database_reset;
    logic        o_database_enable;
    logic [4:0]  o_sweep_done;
    logic        o_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic        sb_en = 1'b1;
    logic [2:0]  q_grant[$];
    logic [2:0]  q_done[$];
    logic [4:0]  exp_done_prev = '0;

    database_scheduler #(
        .NUM_REQ    (5),
        .NUM_STAGES (25),
        .GAP_CYCLES (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .database_request  (req),
        .end_database      (endb),
        .o_grant           (o_grant),
        .o_grant_index     (o_grant_index),
        .o_database_reset  (o_database_reset),
        .o_database_enable (o_database_enable),
        .o_sweep_done      (o_sweep_done),
        .o_busy            (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (o_database_reset !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, " grant wait"}, 32'(k < 20), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (o_busy !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        chk({tag, " idle wait"}, 32'(k < 20), 32'd1);
    endtask

    // Invariants and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        chk("inv grant onehot0", 32'($onehot0(o_grant)), 32'd1);
        chk("inv reset/enable exclusive", 32'(o_database_reset & o_database_enable), 32'd0);
        chk("done follows all-ones end", o_sweep_done, exp_done_prev);
        exp_done_prev <= (reset === 1'b1 && o_database_enable === 1'b1 && &endb) ? o_grant : 5'b0;
        if (sb_en && o_database_reset === 1'b1) begin
            chk("sb grant expected", 32'(q_grant.size() > 0), 32'd1);
            if (q_grant.size() > 0) begin
                chk("sb grant index", o_grant_index, q_grant[0]);
                chk("sb grant vector", o_grant, 5'b1 << q_grant[0]);
                void'(q_grant.pop_front());
            end
        end
        if (sb_en && |o_sweep_done) begin
            chk("sb done expected", 32'(q_done.size() > 0), 32'd1);
            if (q_done.size() > 0) begin
                chk("sb done vector", o_sweep_done, 5'b1 << q_done[0]);
                void'(q_done.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        endb  = '0;
        #1 reset = 1'b0;
        tick(); tick(); tick();
        chk("reset grant", o_grant, 0);
        chk("reset index", o_grant_index, 0);
        chk("reset dbrst", o_database_reset, 0);
        chk("reset enable", o_database_enable, 0);
        chk("reset done", o_sweep_done, 0);
        chk("reset busy", o_busy, 0);
        reset = 1'b1;
        tick();

        // Single requester: latency, sweep, done, gap.
        req = 5'b00100;
        q_grant.push_back(3'd2);
        tick();
        chk("single grant", o_grant, 5'b00100);
        chk("single index", o_grant_index, 2);
        chk("single dbrst", o_database_reset, 1);
        chk("single en at grant", o_database_enable, 0);
        chk("single busy", o_busy, 1);
        tick();
        chk("single en rise", o_database_enable, 1);
        chk("single dbrst fall", o_database_reset, 0);
        tick(); tick();
        endb = '1;
        q_done.push_back(3'd2);
        tick();
        chk("single done", o_sweep_done, 5'b00100);
        chk("single grant drop", o_grant, 0);
        chk("single en drop", o_database_enable, 0);
        req  = '0;
        endb = '0;
        tick();
        chk("single done width", o_sweep_done, 0);
        chk("single release busy", o_busy, 1);
        tick();
        chk("single idle", o_busy, 0);
        chk("single index hold", o_grant_index, 2);

        // Round-robin from a fresh reset: grants 0,1,2,3,4,0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            q_grant.push_back(3'(i % 5));
            q_done.push_back(3'(i % 5));
            wait_grant("rr");
            chk("rr index", o_grant_index, i % 5);
            repeat (4) tick();
            chk("rr enabled", o_database_enable, 1);
            endb = '1;
            tick();
            chk("rr done", o_sweep_done, 5'b1 << (i % 5));
            endb = '0;
            if (i == 5) req = '0;
        end
        wait_idle("rr");

        // Early reject by owner 1 on the third sweep cycle.
        req = 5'b00010;
        q_grant.push_back(3'd1);
        wait_grant("rej");
        tick(); tick(); tick();
        chk("rej en before drop", o_database_enable, 1);
        req = '0;
        tick();
        chk("rej en drop", o_database_enable, 0);
        chk("rej grant drop", o_grant, 0);
        chk("rej no done", o_sweep_done, 0);
        wait_idle("rej");
        req = 5'b00111;
        q_grant.push_back(3'd2);
        wait_grant("rej next");
        chk("rej next index", o_grant_index, 2);
        req = '0;
        tick();
        chk("restart abort grant", o_grant, 0);
        chk("restart abort en", o_database_enable, 0);
        chk("restart abort busy", o_busy, 1);
        wait_idle("abort");

        // Completion and withdrawal in the same cycle: done still issued.
        req = 5'b00001;
        q_grant.push_back(3'd0);
        q_done.push_back(3'd0);
        wait_grant("sim");
        tick(); tick();
        endb = '1;
        req  = '0;
        tick();
        chk("sim done", o_sweep_done, 5'b00001);
        endb = '0;
        wait_idle("sim");

        // End already all-ones on the first sweep cycle.
        endb = '1;
        req  = 5'b01000;
        q_grant.push_back(3'd3);
        q_done.push_back(3'd3);
        wait_grant("pre");
        tick();
        chk("pre en", o_database_enable, 1);
        tick();
        chk("pre done", o_sweep_done, 5'b01000);
        endb = '0;
        req  = '0;
        wait_idle("pre");

        // Asynchronous reset mid-sweep.
        req = 5'b00100;
        q_grant.push_back(3'd2);
        wait_grant("arst");
        tick(); tick();
        chk("arst en before", o_database_enable, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst grant", o_grant, 0);
        chk("arst en", o_database_enable, 0);
        chk("arst busy", o_busy, 0);
        chk("arst index", o_grant_index, 0);
        chk("arst done", o_sweep_done, 0);
        req = '0;
        tick();
        reset = 1'b1;
        req = 5'b11000;
        q_grant.push_back(3'd3);
        wait_grant("arst next");
        chk("arst next grant", o_grant, 5'b01000);
        req = '0;
        wait_idle("arst next");

        chk("grant queue drained", q_grant.size(), 0);
        chk("done queue drained", q_done.size(), 0);

        // Random traffic under invariant checks only.
        sb_en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 5'($urandom_range(0, 31));
            endb = ($urandom_range(0, 4) == 0) ? '1 : 25'($urandom);
            tick();
        end
        req  = '0;
        endb = '0;
        wait_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
